muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
EX-stage controller that sits directly upstream of the multiply/divide unit and consumes its result. It issues MULT/MULTU/DIV/DIVU to the unit and holds its inputs stable for the whole operation. It stalls the pipeline until the unit signals done, then commits the 64-bit result to the architectural HI/LO registers. It also executes MTHI/MTLO and supplies read data for MFHI/MFLO.

Parameters:
DATA_W, 32, operand / HI / LO width
FUNCT_W, 6, funct field width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush; kills the in-flight op and suppresses commit
ex_stall_in  in  1  stall of EX from other sources (e.g. memory)
op_valid  in  1  EX holds a valid instruction
op_funct  in  FUNCT_W  funct of that instruction
op_a  in  DATA_W  rs value
op_b  in  DATA_W  rt value
stall_req  out  1  request to freeze IF..EX
md_funct  out  FUNCT_W  funct to the mult/div unit
md_operand_1  out  DATA_W  operand 1 to the unit
md_operand_2  out  DATA_W  operand 2 to the unit
md_flush  out  1  flush to the unit
md_done  in  1  unit done (one-cycle pulse)
md_result  in  2*DATA_W  {hi, lo} from the unit, valid while md_done=1
hi  out  DATA_W  architectural HI
lo  out  DATA_W  architectural LO
mf_data  out  DATA_W  MFHI→hi, MFLO→lo, otherwise 0

Behaviour:
- Reset (sync, rst=1): hi=lo=0; state=IDLE; hold_result=0; stall_req=0; md_funct=0. Reset takes priority over everything else.
- is_md = op_valid && op_funct ∈ {MULT, MULTU, DIV, DIVU}.
- leave = op_valid && !stall_req && !ex_stall_in && !flush. The instruction leaves EX at the next edge.
- States:
  - IDLE: md_funct=op_funct when is_md, else 0. Operands pass through from op_a/op_b. If is_md and !flush: stall_req=1 and go to BUSY.
  - BUSY: md_funct and operands driven from latched copies taken at issue, stable regardless of op_* changes. stall_req=!md_done.
    - On md_done: latch md_result into hold_result.
    - If ex_stall_in=0: commit {hi,lo}<=md_result and go to IDLE.
    - Else: go to HOLD without committing.
  - HOLD: md_funct=0 so the unit does not restart. stall_req=0. When ex_stall_in drops, commit hold_result to HI/LO at that edge and go to IDLE.
- Latency, issue cycle = C0:
  - MULT*: md_done in C1; commit at end of C1. Stall is asserted for C0 only.
  - DIV*: md_done in C33; commit at end of C33.
- Back-to-back md ops: the second op issues in the cycle after the first commits, with no idle bubble. The unit samples funct after its counter clears.
- MTHI/MTLO: hi<=op_a or lo<=op_a on an edge where leave=1 and state=IDLE.
- MFHI/MFLO: combinational from the current hi/lo. Earlier writes have already committed, so no bypass is needed.
- flush in any state: next state IDLE, md_flush=1, no HI/LO write, latched copies discarded.
- flush coincident with md_done: the flush wins and nothing commits.
- rst in BUSY: same as flush, and hi/lo are also cleared.
- Signed/unsigned sign handling and divide-by-zero values are the unit's responsibility. This block commits whatever md_result holds (divide-by-zero is architecturally UNPREDICTABLE).
- md_result is never sampled outside a cycle with md_done=1.

Decomposition:
- Funct codes (MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B) come from the shared funct define header. Bus widths come from the shared bus header.
- State encoding (IDLE/BUSY/HOLD) is local to this block.
- No sub-module. The mult/div unit is instantiated by the parent EX stage, not inside this block.

Test Plan:
- MULT: op_a=0xFFFFFFFE, op_b=3 → stall_req high for 1 cycle; hi=0xFFFFFFFF, lo=0xFFFFFFFA after the commit edge.
- DIVU: op_a=100, op_b=7 → stall_req high 33 cycles; lo=14, hi=2. md_funct/operands stay constant while op_* are randomized during BUSY.
- DIV -7/2 with ex_stall_in raised in the md_done cycle for 3 cycles → enter HOLD with md_funct=0 and no second md_done; commit lo=0xFFFFFFFD, hi=0xFFFFFFFF when the stall drops.
- flush at cycle 10 of a DIV → md_flush=1, state IDLE next cycle, hi/lo unchanged. The next MULTU 5×6 commits lo=30, hi=0.
- MTLO 0x1234 then MFLO, then MULT immediately followed by MFHI → mf_data=0x1234, then the MULT's hi value. The back-to-back MULT pair shows no idle bubble.
- rst asserted during BUSY → hi=lo=0, stall_req=0 next cycle.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared widths and MIPS SPECIAL funct codes used by the HI/LO controller and its neighbours.
package muldiv_hilo_ctrl_pkg;

    localparam int MD_DATA_W  = 32;
    localparam int MD_FUNCT_W = 6;

    localparam logic [MD_FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [MD_FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    function automatic logic is_md_funct(input logic [MD_FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage controller for the mult/div unit: issues ops, holds operands, stalls the pipe
// until done, and owns the architectural HI/LO registers (MTHI/MTLO/MFHI/MFLO).
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int DATA_W  = MD_DATA_W,
    parameter int FUNCT_W = MD_FUNCT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_stall_in,
    input  logic                  op_valid,
    input  logic [FUNCT_W-1:0]    op_funct,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  stall_req,
    output logic [FUNCT_W-1:0]    md_funct,
    output logic [DATA_W-1:0]     md_operand_1,
    output logic [DATA_W-1:0]     md_operand_2,
    output logic                  md_flush,
    input  logic                  md_done,
    input  logic [2*DATA_W-1:0]   md_result,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic [DATA_W-1:0]     mf_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [FUNCT_W-1:0]  funct_q, funct_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] hold_result_q, hold_result_d;

    logic is_md;
    logic mt_leave;

    assign is_md = op_valid && is_md_funct(MD_FUNCT_W'(op_funct));
    // MTHI/MTLO never stall, so in IDLE the leave condition reduces to this.
    assign mt_leave = op_valid && !ex_stall_in && !flush;

    // NOTE: every output and next-state value gets a default first, so no branch can infer a latch.
    always_comb begin
        state_d       = state_q;
        funct_d       = funct_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        hold_result_d = hold_result_q;
        stall_req     = 1'b0;
        md_funct      = '0;
        md_operand_1  = opa_q;
        md_operand_2  = opb_q;

        unique case (state_q)
            ST_IDLE: begin
                md_funct     = is_md ? op_funct : '0;
                md_operand_1 = op_a;
                md_operand_2 = op_b;
                if (is_md && !flush) begin
                    stall_req = 1'b1;
                    state_d   = ST_BUSY;
                    funct_d   = op_funct;
                    opa_d     = op_a;
                    opb_d     = op_b;
                end else if (mt_leave && op_funct == FUNCT_W'(FUNCT_MTHI)) begin
                    hi_d = op_a;
                end else if (mt_leave && op_funct == FUNCT_W'(FUNCT_MTLO)) begin
                    lo_d = op_a;
                end
            end
            ST_BUSY: begin
                md_funct  = funct_q;
                stall_req = !md_done;
                if (md_done) begin
                    hold_result_d = md_result;
                    if (!ex_stall_in) begin
                        {hi_d, lo_d} = md_result;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // funct stays 0 here so the unit does not restart while the pipe is held.
                if (!ex_stall_in) begin
                    {hi_d, lo_d} = hold_result_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush beats everything, including a coincident md_done.
        if (flush) begin
            state_d       = ST_IDLE;
            funct_d       = '0;
            opa_d         = '0;
            opb_d         = '0;
            hi_d          = hi_q;
            lo_d          = lo_q;
            hold_result_d = hold_result_q;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            funct_q       <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            hold_result_q <= '0;
        end else begin
            state_q       <= state_d;
            funct_q       <= funct_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            hold_result_q <= hold_result_d;
        end
    end

    assign md_flush = flush || rst;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        mf_data = '0;
        if (op_valid && op_funct == FUNCT_W'(FUNCT_MFHI)) begin
            mf_data = hi_q;
        end else if (op_valid && op_funct == FUNCT_W'(FUNCT_MFLO)) begin
            mf_data = lo_q;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: a behavioural mult/div unit plus an instruction-level HI/LO model.
module tb_muldiv_hilo_ctrl;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst, flush, ex_stall_in, op_valid;
    logic [5:0]  op_funct;
    logic [31:0] op_a, op_b;
    logic        stall_req;
    logic [5:0]  md_funct;
    logic [31:0] md_operand_1, md_operand_2;
    logic        md_flush, md_done;
    logic [63:0] md_result;
    logic [31:0] hi, lo, mf_data;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_hilo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ex_stall_in  (ex_stall_in),
        .op_valid     (op_valid),
        .op_funct     (op_funct),
        .op_a         (op_a),
        .op_b         (op_b),
        .stall_req    (stall_req),
        .md_funct     (md_funct),
        .md_operand_1 (md_operand_1),
        .md_operand_2 (md_operand_2),
        .md_flush     (md_flush),
        .md_done      (md_done),
        .md_result    (md_result),
        .hi           (hi),
        .lo           (lo),
        .mf_data      (mf_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_md(input logic [5:0] f);
        return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
    endfunction

    // Architectural {hi, lo} an op produces: product, or {remainder, quotient}.
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] pa, pb;
        logic signed [31:0] sa, sb;
        pa = {{32{a[31]}}, a};
        pb = {{32{b[31]}}, b};
        sa = a;
        sb = b;
        case (f)
            F_MULT:  return pa * pb;
            F_MULTU: return {32'd0, a} * {32'd0, b};
            F_DIV:   return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
            F_DIVU:  return (b == 0) ? 64'd0 : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    // Mult/div unit: MULT* done one cycle after issue, DIV* done 33 cycles after issue.
    int          rem = 0;
    logic [5:0]  u_funct = '0;
    logic [63:0] garbage = '0;

    always @(posedge clk) begin
        garbage <= {$urandom, $urandom};
        if (rst || md_flush) begin
            rem <= 0;
        end else if (rem > 0) begin
            rem <= rem - 1;
        end else if (is_md(md_funct)) begin
            u_funct <= md_funct;
            rem     <= (md_funct == F_MULT || md_funct == F_MULTU) ? 1 : 33;
        end
    end

    assign md_done   = (rem == 1);
    assign md_result = md_done ? ref_result(u_funct, md_operand_1, md_operand_2) : garbage;

    task automatic model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        if (is_md(f)) {exp_hi, exp_lo} = ref_result(f, a, b);
        else if (f == F_MTHI) exp_hi = a;
        else if (f == F_MTLO) exp_lo = a;
    endtask

    // Present one instruction at a negedge and hold it until it leaves EX; returns at a negedge.
    task automatic run_instr(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                             output int stalls);
        bit left;
        left   = 1'b0;
        stalls = 0;
        op_valid = 1'b1; op_funct = f; op_a = a; op_b = b;
        for (int i = 0; i < 100 && !left; i++) begin
            #1;
            if (!stall_req && !ex_stall_in) left = 1'b1;
            else begin
                stalls++;
                @(negedge clk);
            end
        end
        total++;
        if (!left) begin
            bad++;
            $display("FAIL leave_timeout funct=%h stalls=%0d required leave within 100 cycles", f, stalls);
        end else begin
            @(negedge clk);
            model_apply(f, a, b);
        end
        op_valid = 1'b0;
        op_funct = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_stall_in = 1'b0; op_valid = 1'b0;
        op_funct = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_req); end
        total++; if (md_funct !== 6'd0) begin bad++; $display("FAIL reset_md_funct got=%h want=0", md_funct); end
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int st;
        run_instr(F_MULT, 32'hFFFF_FFFE, 32'd3, st);
        total++; if (st !== 1) begin bad++; $display("FAIL mult_stall got=%0d want=1", st); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h want=fffffffa", lo); end
    endtask

    task automatic test_divu_stable();
        int  stalls, unstable;
        bit  left;
        stalls = 0; unstable = 0; left = 1'b0;
        op_valid = 1'b1; op_funct = F_DIVU; op_a = 32'd100; op_b = 32'd7;
        #1;
        if (stall_req) stalls++;
        for (int i = 0; i < 60 && !left; i++) begin
            @(negedge clk);
            op_a = $urandom; op_b = $urandom; op_funct = 6'($urandom);
            #1;
            if (md_funct !== F_DIVU || md_operand_1 !== 32'd100 || md_operand_2 !== 32'd7)
                unstable++;
            if (stall_req) stalls++;
            else left = 1'b1;
        end
        @(negedge clk);
        op_valid = 1'b0; op_funct = '0;
        if (left) model_apply(F_DIVU, 32'd100, 32'd7);
        total++; if (stalls !== 33) begin bad++; $display("FAIL divu_stall got=%0d want=33", stalls); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL divu_unstable_cycles got=%0d want=0", unstable); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%0d want=14", lo); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%0d want=2", hi); end
    endtask

    task automatic test_div_hold();
        logic [31:0] old_hi, old_lo;
        int          holdbad;
        bit          seen;
        old_hi = exp_hi; old_lo = exp_lo; holdbad = 0; seen = 1'b0;
        op_valid = 1'b1; op_funct = F_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        for (int i = 0; i < 60 && !seen; i++) begin
            #1;
            if (md_done) seen = 1'b1;
            else @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL hold_done_timeout got=0 want=md_done"); end
        ex_stall_in = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            if (md_funct !== 6'd0 || md_done !== 1'b0 || stall_req !== 1'b0 ||
                hi !== old_hi || lo !== old_lo) holdbad++;
        end
        @(negedge clk);
        ex_stall_in = 1'b0;
        #1;
        if (md_funct !== 6'd0 || md_done !== 1'b0) holdbad++;
        @(negedge clk);
        op_valid = 1'b0; op_funct = '0;
        model_apply(F_DIV, 32'hFFFF_FFF9, 32'd2);
        total++; if (holdbad !== 0) begin bad++; $display("FAIL hold_cycles_bad got=%0d want=0", holdbad); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL hold_lo got=%h want=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hold_hi got=%h want=ffffffff", hi); end
    endtask

    task automatic test_flush();
        int st;
        op_valid = 1'b1; op_funct = F_DIV; op_a = $urandom; op_b = $urandom_range(1, 1000);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        total++; if (md_flush !== 1'b1) begin bad++; $display("FAIL flush_md_flush got=%b want=1", md_flush); end
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0; op_funct = '0;
        #1;
        total++; if (stall_req !== 1'b0 || md_funct !== 6'd0) begin
            bad++; $display("FAIL flush_idle stall=%b md_funct=%h want stall=0 md_funct=0", stall_req, md_funct);
        end
        repeat (30) @(negedge clk);
        total++; if (hi !== exp_hi || lo !== exp_lo) begin
            bad++; $display("FAIL flush_hilo got=%h_%h want=%h_%h", hi, lo, exp_hi, exp_lo);
        end
        run_instr(F_MULTU, 32'd5, 32'd6, st);
        total++; if (lo !== 32'd30 || hi !== 32'd0) begin
            bad++; $display("FAIL flush_multu got=%h_%h want=00000000_0000001e", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int st1, st2, c0;
        run_instr(F_MTLO, 32'h1234, 32'd0, st1);
        op_valid = 1'b1; op_funct = F_MFLO;
        #1;
        total++; if (mf_data !== 32'h1234) begin bad++; $display("FAIL mflo_data got=%h want=00001234", mf_data); end
        @(negedge clk);
        c0 = cyc;
        run_instr(F_MULT, $urandom, $urandom, st1);
        run_instr(F_MULT, $urandom, $urandom, st2);
        total++; if (cyc - c0 !== 4 || st1 !== 1 || st2 !== 1) begin
            bad++; $display("FAIL b2b_cycles got=%0d stalls=%0d/%0d want=4 stalls=1/1", cyc - c0, st1, st2);
        end
        op_valid = 1'b1; op_funct = F_MFHI;
        #1;
        total++; if (mf_data !== exp_hi) begin bad++; $display("FAIL mfhi_data got=%h want=%h", mf_data, exp_hi); end
        total++; if (lo !== exp_lo) begin bad++; $display("FAIL b2b_lo got=%h want=%h", lo, exp_lo); end
        @(negedge clk);
        op_valid = 1'b0; op_funct = '0;
    endtask

    task automatic test_random();
        logic [5:0]  ops [8];
        logic [5:0]  f;
        logic [31:0] a, b;
        int          st;
        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
        for (int n = 0; n < 24; n++) begin
            f = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom_range(1, 1000);
            if (f == F_MFHI || f == F_MFLO) begin
                op_valid = 1'b1; op_funct = f;
                #1;
                total++; if (mf_data !== ((f == F_MFHI) ? exp_hi : exp_lo)) begin
                    bad++; $display("FAIL rand_mf n=%0d got=%h want=%h", n, mf_data,
                                    (f == F_MFHI) ? exp_hi : exp_lo);
                end
                @(negedge clk);
                op_valid = 1'b0; op_funct = '0;
            end else begin
                run_instr(f, a, b, st);
                if (is_md(f)) begin
                    total++; if (st !== ((f == F_MULT || f == F_MULTU) ? 1 : 33)) begin
                        bad++; $display("FAIL rand_stall n=%0d funct=%h got=%0d", n, f, st);
                    end
                end
                total++; if (hi !== exp_hi || lo !== exp_lo) begin
                    bad++; $display("FAIL rand_hilo n=%0d funct=%h got=%h_%h want=%h_%h", n, f, hi, lo, exp_hi, exp_lo);
                end
            end
        end
    endtask

    task automatic test_rst_busy();
        op_valid = 1'b1; op_funct = F_DIVU; op_a = $urandom; op_b = $urandom_range(1, 1000);
        repeat (5) @(negedge clk);
        rst = 1'b1; op_valid = 1'b0; op_funct = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        #1;
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++; $display("FAIL rst_busy_hilo got=%h_%h want=0_0", hi, lo);
        end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_busy_stall got=%b want=0", stall_req); end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_divu_stable();
        test_div_hold();
        test_flush();
        test_back_to_back();
        test_random();
        test_rst_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
